// File: rtl/datapath_sequencer.sv
// Issue stage in front of the regfile + ALU32 datapath: accepts 10-bit micro-instructions,
// sequences each one through EXEC/WB, captures the datapath flags and counts retirements.
module datapath_sequencer #(
  parameter int CNT_W    = 16,
  parameter int OVF_TRAP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [9:0]       instr,
  input  logic             Zero,
  input  logic             Overflow,
  output logic [2:0]       ALUControl,
  output logic [1:0]       addr1,
  output logic [1:0]       addr2,
  output logic [1:0]       addr3,
  output logic             wr,
  output logic             flag_z,
  output logic             flag_v,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  input  logic             clear_halt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_reg;
  logic   nowr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      nowr_reg    <= 1'b0;
      instr_ready <= 1'b0;
      ALUControl  <= 3'd0;
      addr1       <= 2'd0;
      addr2       <= 2'd0;
      addr3       <= 2'd0;
      wr          <= 1'b0;
      flag_z      <= 1'b0;
      flag_v      <= 1'b0;
      retired     <= '0;
      halted      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // The first edge out of reset only raises ready; accepts need ready already high.
          if (!instr_ready) begin
            instr_ready <= 1'b1;
          end else if (instr_valid) begin
            nowr_reg    <= instr[9];
            ALUControl  <= instr[8:6];
            addr1       <= instr[5:4];
            addr2       <= instr[3:2];
            addr3       <= instr[1:0];
            instr_ready <= 1'b0;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          // wr is registered, so it is raised here to be high for the whole WB cycle.
          wr        <= ~nowr_reg;
          state_reg <= WB;
        end
        WB: begin
          wr      <= 1'b0;
          flag_z  <= Zero;
          flag_v  <= Overflow;
          retired <= retired + CNT_ONE;
          if ((OVF_TRAP != 0) && Overflow) begin
            halted    <= 1'b1;
            state_reg <= HALT;
          end else begin
            instr_ready <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        HALT: begin
          if (clear_halt) begin
            halted      <= 1'b0;
            instr_ready <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized self-checking bench for datapath_sequencer; a 16-bit and a 2-bit counter
// instance share stimulus and are checked against a transaction-level model.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [9:0]  instr = 10'd0;
  logic        Zero = 1'b0;
  logic        Overflow = 1'b0;
  logic        clear_halt = 1'b0;

  logic        instr_ready, wr, flag_z, flag_v, halted;
  logic [2:0]  ALUControl;
  logic [1:0]  addr1, addr2, addr3;
  logic [15:0] retired;

  logic        instr_ready_w, wr_w, flag_z_w, flag_v_w, halted_w;
  logic [2:0]  ALUControl_w;
  logic [1:0]  addr1_w, addr2_w, addr3_w;
  logic [1:0]  retired_w;

  always #5 clk = ~clk;

  datapath_sequencer #(.CNT_W(16), .OVF_TRAP(1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .Zero(Zero), .Overflow(Overflow), .ALUControl(ALUControl),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .wr(wr), .flag_z(flag_z),
    .flag_v(flag_v), .retired(retired), .halted(halted), .clear_halt(clear_halt)
  );

  datapath_sequencer #(.CNT_W(2), .OVF_TRAP(1)) dut_w (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready_w),
    .instr(instr), .Zero(Zero), .Overflow(Overflow), .ALUControl(ALUControl_w),
    .addr1(addr1_w), .addr2(addr2_w), .addr3(addr3_w), .wr(wr_w), .flag_z(flag_z_w),
    .flag_v(flag_v_w), .retired(retired_w), .halted(halted_w), .clear_halt(clear_halt)
  );

  int checks = 0;
  int fails = 0;

  // Transaction-level model: what the architectural state should be after each retirement.
  int unsigned m_retired = 0;
  logic        m_z = 1'b0, m_v = 1'b0, m_halted = 1'b0;

  // Observations captured while an instruction flows through.
  bit          o_ok;
  int          o_wait;
  logic [2:0]  o_alu;
  logic [1:0]  o_a1, o_a2, o_a3;
  logic        o_wr_exec, o_wr_wb;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one instruction (bounded wait for ready), feed Zero/Overflow in WB, record what was seen.
  task automatic issue(input logic [9:0] ins, input logic z, input logic v, input bit hold);
    logic rdy;
    o_ok = 0;
    o_wait = 0;
    for (int i = 0; i < 12; i++) begin
      instr = ins;
      instr_valid = 1'b1;
      rdy = instr_ready;
      @(posedge clk); @(negedge clk);
      if (rdy) begin
        o_ok = 1;
        break;
      end
      o_wait++;
    end
    if (!hold) instr_valid = 1'b0;
    if (!o_ok) return;
    o_alu = ALUControl; o_a1 = addr1; o_a2 = addr2; o_a3 = addr3;
    o_wr_exec = wr;
    @(posedge clk); @(negedge clk);
    o_wr_wb = wr;
    Zero = z;
    Overflow = v;
    @(posedge clk); @(negedge clk);
    Zero = 1'b0;
    Overflow = 1'b0;
    m_retired++;
    m_z = z;
    m_v = v;
    m_halted = v;
  endtask

  task automatic model_reset();
    m_retired = 0; m_z = 1'b0; m_v = 1'b0; m_halted = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({instr_ready, ALUControl, addr1, addr2, addr3, wr, flag_z, flag_v, halted} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0", {instr_ready, ALUControl, addr1, addr2, addr3, wr, flag_z, flag_v, halted});
    end
    checks++;
    if (retired !== 16'd0) begin fails++; $display("FAIL reset_retired: got %0d required 0", retired); end
    rst = 1'b1;
    model_reset();
    @(posedge clk); @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b required 1", instr_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (wr !== 1'b0 || instr_ready !== 1'b1) begin
        fails++; $display("FAIL idle_quiet: wr=%b ready=%b required wr=0 ready=1", wr, instr_ready);
      end
    end
  endtask

  task automatic test_single_add();
    issue(10'b0_000_11_11_01, 1'b0, 1'b0, 0);
    $display("single_add: ok=%0d alu=%0d a1=%0d a2=%0d a3=%0d wr_exec=%b wr_wb=%b retired=%0d", o_ok, o_alu, o_a1, o_a2, o_a3, o_wr_exec, o_wr_wb, retired);
    checks++;
    if (!o_ok) begin fails++; $display("FAIL add_accept: not accepted within bound"); end
    checks++;
    if ({o_alu, o_a1, o_a2, o_a3} !== {3'd0, 2'd3, 2'd3, 2'd1}) begin
      fails++; $display("FAIL add_decode: got %h required %h", {o_alu, o_a1, o_a2, o_a3}, {3'd0, 2'd3, 2'd3, 2'd1});
    end
    checks++;
    if (o_wr_exec !== 1'b0 || o_wr_wb !== 1'b1) begin
      fails++; $display("FAIL add_wr_timing: exec=%b wb=%b required exec=0 wb=1", o_wr_exec, o_wr_wb);
    end
    checks++;
    if (retired !== m_retired[15:0]) begin fails++; $display("FAIL add_retired: got %0d required %0d", retired, m_retired); end
    checks++;
    if (instr_ready !== 1'b1 || wr !== 1'b0) begin
      fails++; $display("FAIL add_return_idle: ready=%b wr=%b required 1/0", instr_ready, wr);
    end
  endtask

  task automatic test_compare_flags();
    issue(10'b1_001_01_01_01, 1'b1, 1'b0, 0);
    $display("compare: ok=%0d wr_wb=%b flag_z=%b flag_v=%b retired=%0d", o_ok, o_wr_wb, flag_z, flag_v, retired);
    checks++;
    if (!o_ok || o_wr_wb !== 1'b0) begin fails++; $display("FAIL cmp_no_write: ok=%0d wr=%b required wr=0", o_ok, o_wr_wb); end
    checks++;
    if (flag_z !== 1'b1 || flag_v !== 1'b0) begin
      fails++; $display("FAIL cmp_flags: z=%b v=%b required z=1 v=0", flag_z, flag_v);
    end
    checks++;
    if (retired !== m_retired[15:0]) begin fails++; $display("FAIL cmp_retired: got %0d required %0d", retired, m_retired); end
  endtask

  task automatic test_trap();
    logic [15:0] ret_hold;
    issue(10'b0_010_10_01_11, 1'b0, 1'b1, 0);
    $display("trap: ok=%0d wr_wb=%b halted=%b ready=%b flag_v=%b retired=%0d", o_ok, o_wr_wb, halted, instr_ready, flag_v, retired);
    checks++;
    if (!o_ok || o_wr_wb !== 1'b1) begin fails++; $display("FAIL trap_write: ok=%0d wr=%b required wr=1", o_ok, o_wr_wb); end
    checks++;
    if (halted !== 1'b1 || instr_ready !== 1'b0 || flag_v !== 1'b1) begin
      fails++; $display("FAIL trap_halt: halted=%b ready=%b v=%b required 1/0/1", halted, instr_ready, flag_v);
    end
    checks++;
    if (retired !== m_retired[15:0]) begin fails++; $display("FAIL trap_retired: got %0d required %0d", retired, m_retired); end
    ret_hold = retired;
    instr = 10'b0_111_00_00_00;
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (wr !== 1'b0 || ALUControl !== 3'b010 || retired !== ret_hold || halted !== 1'b1) begin
        fails++; $display("FAIL halt_ignores_valid: wr=%b alu=%0d retired=%0d halted=%b", wr, ALUControl, retired, halted);
      end
    end
    instr_valid = 1'b0;
    clear_halt = 1'b1;
    @(posedge clk); @(negedge clk);
    clear_halt = 1'b0;
    m_halted = 1'b0;
    checks++;
    if (halted !== 1'b0 || instr_ready !== 1'b1) begin
      fails++; $display("FAIL clear_halt: halted=%b ready=%b required 0/1", halted, instr_ready);
    end
    clear_halt = 1'b1;
    @(posedge clk); @(negedge clk);
    clear_halt = 1'b0;
    checks++;
    if (halted !== 1'b0 || instr_ready !== 1'b1 || retired !== ret_hold) begin
      fails++; $display("FAIL clear_outside_halt: halted=%b ready=%b retired=%0d", halted, instr_ready, retired);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] ins;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      ins = 10'($urandom);
      ins[9] = 1'b0;
      issue(ins, 1'($urandom), 1'b0, 1);
      $display("b2b[%0d]: instr=%h wait=%0d alu=%0d a=%0d/%0d/%0d retired=%0d retired_w=%0d", k, ins, o_wait, o_alu, o_a1, o_a2, o_a3, retired, retired_w);
      checks++;
      if (!o_ok || o_wait !== 0) begin fails++; $display("FAIL b2b_rate: ok=%0d waited=%0d required 0", o_ok, o_wait); end
      checks++;
      if ({o_alu, o_a1, o_a2, o_a3} !== ins[8:0]) begin
        fails++; $display("FAIL b2b_decode: got %h required %h", {o_alu, o_a1, o_a2, o_a3}, ins[8:0]);
      end
      checks++;
      if (retired !== m_retired[15:0]) begin fails++; $display("FAIL b2b_retired: got %0d required %0d", retired, m_retired); end
    end
    instr_valid = 1'b0;
    checks++;
    if (retired_w !== 2'd1) begin fails++; $display("FAIL wrap_cnt2: got %0d required 1", retired_w); end
  endtask

  task automatic test_async_reset_wb();
    while (instr_ready !== 1'b1) begin @(posedge clk); @(negedge clk); end
    instr = 10'b0_011_00_01_10;
    instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (wr !== 1'b1) begin fails++; $display("FAIL wb_wr_before_reset: got %b required 1", wr); end
    #2 rst = 1'b0;
    #1;
    $display("async_reset: wr=%b retired=%0d z=%b v=%b ready=%b", wr, retired, flag_z, flag_v, instr_ready);
    checks++;
    if ({wr, flag_z, flag_v, halted, instr_ready} !== 5'd0 || retired !== 16'd0) begin
      fails++; $display("FAIL async_clear: wr=%b z=%b v=%b h=%b rdy=%b retired=%0d", wr, flag_z, flag_v, halted, instr_ready, retired);
    end
    model_reset();
    instr = 10'b0_101_11_10_01;
    instr_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (instr_ready !== 1'b0 || ALUControl !== 3'd0 || wr !== 1'b0) begin
      fails++; $display("FAIL held_in_reset: rdy=%b alu=%0d wr=%b required 0", instr_ready, ALUControl, wr);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || ALUControl !== 3'd0) begin
      fails++; $display("FAIL first_edge_no_accept: rdy=%b alu=%0d required 1/0", instr_ready, ALUControl);
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [9:0] ins;
    logic z, v;
    for (int k = 0; k < 40; k++) begin
      ins = 10'($urandom);
      z = 1'($urandom);
      v = ($urandom_range(0, 5) == 0);
      issue(ins, z, v, bit'($urandom_range(0, 1)));
      $display("rand[%0d]: instr=%h z=%b v=%b wr_wb=%b retired=%0d/%0d halted=%b", k, ins, z, v, o_wr_wb, retired, retired_w, halted);
      checks++;
      if (!o_ok) begin fails++; $display("FAIL rand_accept: not accepted within bound"); end
      checks++;
      if ({o_alu, o_a1, o_a2, o_a3} !== ins[8:0] || o_wr_exec !== 1'b0 || o_wr_wb !== ~ins[9]) begin
        fails++; $display("FAIL rand_issue: got %h exec_wr=%b wb_wr=%b required %h 0 %b", {o_alu, o_a1, o_a2, o_a3}, o_wr_exec, o_wr_wb, ins[8:0], ~ins[9]);
      end
      checks++;
      if (retired !== m_retired[15:0] || retired_w !== m_retired[1:0]) begin
        fails++; $display("FAIL rand_retired: got %0d/%0d required %0d/%0d", retired, retired_w, m_retired[15:0], m_retired[1:0]);
      end
      checks++;
      if (flag_z !== m_z || flag_v !== m_v || halted !== m_halted || instr_ready !== ~m_halted) begin
        fails++; $display("FAIL rand_state: z=%b v=%b h=%b rdy=%b required %b %b %b %b", flag_z, flag_v, halted, instr_ready, m_z, m_v, m_halted, ~m_halted);
      end
      if (m_halted) begin
        instr_valid = 1'b0;
        clear_halt = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_halt = 1'b0;
        m_halted = 1'b0;
      end
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_add();
    test_compare_flags();
    test_trap();
    test_back_to_back();
    test_async_reset_wb();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
